// File: rtl/irq_controller_nested.sv
// Nested vectored interrupt controller: edge capture, masked priority pick, req/ack, PC/ID stack.
// Latency: source edge to irq_req 2 clks, ack/iret to addr_valid 1 clk; the request holds until ack, iret or loss of candidate.
module irq_controller_nested #(
  parameter int                NUM_INT    = 16,
  parameter int                ADDR_W     = 16,
  parameter int                NEST_DEPTH = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0100,
  parameter int                VEC_STRIDE = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_INT-1:0]         irq_src,
  input  logic                       ier_we,
  input  logic [NUM_INT:0]           ier_wdata,
  output logic [NUM_INT:0]           ier_q,
  input  logic [NUM_INT-1:0]         pend_clr,
  output logic [NUM_INT-1:0]         pending,
  output logic                       irq_req,
  output logic [$clog2(NUM_INT)-1:0] irq_id,
  input  logic                       irq_ack,
  input  logic [ADDR_W-1:0]          ret_pc,
  input  logic                       iret,
  output logic                       addr_valid,
  output logic [ADDR_W-1:0]          addr_out,
  output logic                       act_valid,
  output logic [$clog2(NUM_INT)-1:0] act_id,
  output logic                       iret_err
);
  localparam int IDW = $clog2(NUM_INT);
  localparam int DW  = $clog2(NEST_DEPTH + 1);
  localparam int PW  = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DISPATCH, RETURN} state_t;

  state_t              state_q, state_d;
  logic [NUM_INT:0]    ier_d;
  logic [NUM_INT-1:0]  pend_q, pend_d, hist_q, hist_d;
  logic [ADDR_W-1:0]   pc_stk_q [NEST_DEPTH];
  logic [ADDR_W-1:0]   pc_stk_d [NEST_DEPTH];
  logic [IDW-1:0]      id_stk_q [NEST_DEPTH];
  logic [IDW-1:0]      id_stk_d [NEST_DEPTH];
  logic [DW-1:0]       depth_q, depth_d, depth_m1;
  logic                iret_err_q, iret_err_d;
  logic                irq_req_q, irq_req_d;
  logic [IDW-1:0]      irq_id_q, irq_id_d;
  logic                addr_valid_q, addr_valid_d;
  logic [ADDR_W-1:0]   addr_out_q, addr_out_d;

  logic [NUM_INT-1:0]  elig, ack_clr;
  logic [IDW-1:0]      cand;
  logic                cand_any, cand_vld, pop, push;
  logic [PW-1:0]       top_idx;

  assign elig     = pend_q & ier_q[NUM_INT-1:0] & {NUM_INT{ier_q[NUM_INT]}};
  assign depth_m1 = depth_q - DW'(1);
  assign top_idx  = depth_m1[PW-1:0];

  assign act_valid  = (depth_q != '0);
  assign act_id     = act_valid ? id_stk_q[top_idx] : '0;
  assign pending    = pend_q;
  assign irq_req    = irq_req_q;
  assign irq_id     = irq_id_q;
  assign addr_valid = addr_valid_q;
  assign addr_out   = addr_out_q;
  assign iret_err   = iret_err_q;

  // Lowest index wins; scan from the top so the last hit is the smallest.
  always_comb begin
    cand     = '0;
    cand_any = 1'b0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (elig[i]) begin
        cand     = IDW'(i);
        cand_any = 1'b1;
      end
    end
  end

  assign cand_vld = cand_any && (depth_q != DW'(NEST_DEPTH)) && (!act_valid || (cand < act_id));

  always_comb begin
    state_d      = state_q;
    ier_d        = ier_we ? ier_wdata : ier_q;
    hist_d       = irq_src;
    pc_stk_d     = pc_stk_q;
    id_stk_d     = id_stk_q;
    depth_d      = depth_q;
    iret_err_d   = iret_err_q;
    irq_req_d    = 1'b0;
    irq_id_d     = '0;
    addr_valid_d = 1'b0;
    addr_out_d   = '0;
    ack_clr      = '0;
    pop          = 1'b0;
    push         = 1'b0;

    case (state_q)
      IDLE: begin
        if (iret) begin
          state_d = RETURN;
          pop     = 1'b1;
        end else if (cand_vld) begin
          state_d   = REQ;
          irq_req_d = 1'b1;
          irq_id_d  = cand;
        end
      end
      REQ: begin
        if (iret) begin
          state_d = RETURN;
          pop     = 1'b1;
        end else if (!cand_vld) begin
          state_d = IDLE;
        end else if (irq_ack) begin
          state_d = DISPATCH;
          push    = 1'b1;
        end else begin
          irq_req_d = 1'b1;
          irq_id_d  = cand;
        end
      end
      default: state_d = IDLE;
    endcase

    // The vector is registered on the ack edge so it is presented during DISPATCH.
    if (push) begin
      pc_stk_d[depth_q[PW-1:0]] = ret_pc;
      id_stk_d[depth_q[PW-1:0]] = irq_id_q;
      depth_d                   = depth_q + DW'(1);
      ack_clr                   = NUM_INT'(1) << irq_id_q;
      addr_valid_d              = 1'b1;
      addr_out_d                = VEC_BASE + ADDR_W'(irq_id_q) * ADDR_W'(VEC_STRIDE);
    end

    if (pop) begin
      if (act_valid) begin
        addr_valid_d = 1'b1;
        addr_out_d   = pc_stk_q[top_idx];
        depth_d      = depth_m1;
      end else begin
        iret_err_d = 1'b1;
      end
    end

    pend_d = (pend_q & ~pend_clr & ~ack_clr) | (irq_src & ~hist_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      ier_q        <= '0;
      pend_q       <= '0;
      hist_q       <= '0;
      pc_stk_q     <= '{default: '0};
      id_stk_q     <= '{default: '0};
      depth_q      <= '0;
      iret_err_q   <= 1'b0;
      irq_req_q    <= 1'b0;
      irq_id_q     <= '0;
      addr_valid_q <= 1'b0;
      addr_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      ier_q        <= ier_d;
      pend_q       <= pend_d;
      hist_q       <= hist_d;
      pc_stk_q     <= pc_stk_d;
      id_stk_q     <= id_stk_d;
      depth_q      <= depth_d;
      iret_err_q   <= iret_err_d;
      irq_req_q    <= irq_req_d;
      irq_id_q     <= irq_id_d;
      addr_valid_q <= addr_valid_d;
      addr_out_q   <= addr_out_d;
    end
  end
endmodule

// File: tb/tb_irq_controller_nested.sv
// Scoreboarded bench: tasks drive the CPU side and queue expected addresses; a negedge monitor checks them.
module tb_irq_controller_nested;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] irq_src = '0;
  logic        ier_we = 1'b0;
  logic [16:0] ier_wdata = '0;
  logic [16:0] ier_q;
  logic [15:0] pend_clr = '0;
  logic [15:0] pending;
  logic        irq_req;
  logic [3:0]  irq_id;
  logic        irq_ack = 1'b0;
  logic [15:0] ret_pc = '0;
  logic        iret = 1'b0;
  logic        addr_valid;
  logic [15:0] addr_out;
  logic        act_valid;
  logic [3:0]  act_id;
  logic        iret_err;

  irq_controller_nested dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .ier_we(ier_we), .ier_wdata(ier_wdata),
    .ier_q(ier_q), .pend_clr(pend_clr), .pending(pending), .irq_req(irq_req),
    .irq_id(irq_id), .irq_ack(irq_ack), .ret_pc(ret_pc), .iret(iret),
    .addr_valid(addr_valid), .addr_out(addr_out), .act_valid(act_valid),
    .act_id(act_id), .iret_err(iret_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [15:0] m_pend, m_prev, m_ackclr;
  logic [16:0] m_ier;
  logic        m_err;
  int          m_ids[$];
  int          m_pcs[$];
  int          exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock, applying the spec's register rules to the model for that edge.
  task automatic tick();
    if (!rst) begin
      m_pend = '0; m_prev = '0; m_ier = '0; m_err = 1'b0;
      m_ids.delete(); m_pcs.delete();
    end else begin
      m_pend = (m_pend & ~pend_clr & ~m_ackclr) | (irq_src & ~m_prev);
      m_prev = irq_src;
      if (ier_we) m_ier = ier_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int model_cand();
    logic [15:0] elig;
    int limit;
    elig  = m_ier[16] ? (m_pend & m_ier[15:0]) : 16'h0;
    limit = (m_ids.size() == 0) ? N : m_ids[$];
    if (m_ids.size() >= 4) return -1;
    for (int i = 0; i < limit; i++) if (elig[i]) return i;
    return -1;
  endfunction

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(); rst = 1'b1;
  endtask

  task automatic wr_ier(input logic [16:0] v);
    ier_we = 1'b1; ier_wdata = v; tick(); ier_we = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] m, input logic [15:0] clr);
    irq_src = m; pend_clr = clr; tick();
    irq_src = '0; pend_clr = '0; tick();
  endtask

  task automatic check_state();
    chk("pending", pending, m_pend);
    chk("ier_q", ier_q, m_ier);
    chk("act_valid", act_valid, m_ids.size() != 0);
    chk("act_id", act_id, (m_ids.size() != 0) ? m_ids[$] : 0);
    chk("iret_err", iret_err, m_err);
  endtask

  task automatic service(input logic [15:0] pc);
    int c;
    c = model_cand();
    if (c < 0) begin
      chk("irq_req_idle", irq_req, 1'b0);
      return;
    end
    chk("irq_req", irq_req, 1'b1);
    chk("irq_id", irq_id, c);
    if (irq_req !== 1'b1) return;
    exp_q.push_back(16'h0100 + c * 4);
    irq_ack = 1'b1; ret_pc = pc; m_ackclr = 16'(1) << c;
    tick();
    irq_ack = 1'b0; m_ackclr = '0;
    m_ids.push_back(c); m_pcs.push_back(int'(pc));
    settle(4);
  endtask

  task automatic do_iret();
    if (m_ids.size() != 0) begin
      exp_q.push_back(m_pcs[$]);
      void'(m_ids.pop_back()); void'(m_pcs.pop_back());
    end else begin
      m_err = 1'b1;
    end
    iret = 1'b1; tick(); iret = 1'b0;
    settle(4);
    chk("iret_err_after_iret", iret_err, m_err);
  endtask

  // Monitor: every addr_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (addr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_addr_valid actual=1 required=0 addr_out=0x%0h at %0t", addr_out, $time);
      end else begin
        chk("addr_out", addr_out, exp_q.pop_front());
      end
    end else begin
      chk("addr_out_idle", addr_out, 16'h0);
    end
  end

  initial begin
    m_pend = '0; m_prev = '0; m_ier = '0; m_err = 1'b0; m_ackclr = '0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_irq_req", irq_req, 1'b0);
    chk("rst_irq_id", irq_id, 4'h0);
    chk("rst_addr_valid", addr_valid, 1'b0);
    check_state();

    // Single interrupt: latency, vector, return
    wr_ier(17'h1_0008);
    irq_src = 16'h0008; tick();
    chk("lat_pend", pending, 16'h0008);
    chk("lat_req0", irq_req, 1'b0);
    irq_src = '0; tick();
    chk("lat_req1", irq_req, 1'b1);
    chk("lat_id", irq_id, 4'd3);
    exp_q.push_back(16'h010C);
    irq_ack = 1'b1; ret_pc = 16'h0040; m_ackclr = 16'h0008; tick();
    irq_ack = 1'b0; m_ackclr = '0; m_ids.push_back(3); m_pcs.push_back(16'h0040);
    chk("disp_valid", addr_valid, 1'b1);
    chk("disp_addr", addr_out, 16'h010C);
    chk("disp_pend", pending, 16'h0000);
    chk("disp_act_id", act_id, 4'd3);
    settle(2);
    exp_q.push_back(16'h0040); void'(m_ids.pop_back()); void'(m_pcs.pop_back());
    iret = 1'b1; tick(); iret = 1'b0;
    chk("ret_valid", addr_valid, 1'b1);
    chk("ret_addr", addr_out, 16'h0040);
    chk("ret_act_valid", act_valid, 1'b0);
    settle(2);

    // Priority, preemption and blocking of lower priority
    wr_ier(17'h1_FFFF);
    pulse(16'h0024, 16'h0); settle(2);
    chk("prio_id2", irq_id, 4'd2);
    service(16'h1111);
    chk("no_id5_while_2", irq_req, 1'b0);
    do_iret();
    service(16'h2222);
    chk("act5", act_id, 4'd5);
    pulse(16'h0042, 16'h0); settle(2);
    chk("preempt_id1", irq_id, 4'd1);
    service(16'h3333);
    chk("no_id6_while_1", irq_req, 1'b0);
    do_iret(); do_iret();
    check_state();

    // Full nesting, overflow guard, underflow error
    do_reset();
    wr_ier(17'h1_FFFF);
    for (int k = 3; k >= 0; k--) begin
      pulse(16'(1) << k, 16'h0); settle(2);
      service(16'(16'h0A00 + k));
    end
    pulse(16'hFFFF, 16'h0); settle(3);
    chk("full_no_req", irq_req, 1'b0);
    for (int k = 0; k < 4; k++) do_iret();
    do_iret();
    chk("underflow_err", iret_err, 1'b1);
    check_state();

    // Global enable and reset during REQ
    do_reset();
    wr_ier(17'h0_FFFF);
    pulse(16'h0010, 16'h0); settle(2);
    chk("genoff_pend", pending, 16'h0010);
    chk("genoff_req", irq_req, 1'b0);
    wr_ier(17'h1_FFFF); settle(2);
    chk("genon_req", irq_req, 1'b1);
    chk("genon_id", irq_id, 4'd4);
    do_reset();
    chk("rstreq_req", irq_req, 1'b0);
    chk("rstreq_addr_valid", addr_valid, 1'b0);
    check_state();

    // Randomized traffic
    wr_ier(17'h1_FFFF);
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r < 4) begin
        logic [15:0] m, c;
        m = 16'($urandom & $urandom & $urandom);
        c = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
        pulse(m, c);
        settle(3);
      end else if (r < 8) begin
        service(16'($urandom));
      end else if (r < 11) begin
        do_iret();
      end else begin
        wr_ier({($urandom_range(0, 4) != 0), 16'($urandom | $urandom)});
        settle(3);
      end
      check_state();
      if (it % 100 == 99) begin
        do_reset();
        wr_ier(17'h1_FFFF);
      end
    end

    settle(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/irq_controller_nested.md
Name: irq_controller_nested

Overview:
- Parametrised vectored interrupt controller for the 16-bit single-cycle CPU.
- Captures edge-triggered interrupt sources into a pending register and masks them with an enable register that carries a global-enable bit.
- Picks the highest-priority eligible source and requests service from the CPU with a req/ack handshake.
- Supports nested preemption through a return-address/ID stack; on `iret` it supplies either the handler vector or the saved return PC on `addr_out`.

Parameters:
- NUM_INT, 16: number of interrupt sources. Index 0 has the highest priority.
- ADDR_W, 16: width of the PC and vector address.
- NEST_DEPTH, 4: maximum number of nested active interrupts (stack entries).
- VEC_BASE, 16'h0100: address of the handler for source 0.
- VEC_STRIDE, 4: address spacing between consecutive handler vectors.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- irq_src  in  NUM_INT  raw interrupt sources; a rising edge sets the matching pending bit.
- ier_we  in  1  write strobe for the enable register.
- ier_wdata  in  NUM_INT+1  enable-register write data; bit NUM_INT is the global enable.
- ier_q  out  NUM_INT+1  current enable-register value.
- pend_clr  in  NUM_INT  write-1-to-clear for pending bits.
- pending  out  NUM_INT  current pending-register value.
- irq_req  out  1  service request to the CPU.
- irq_id  out  $clog2(NUM_INT)  ID of the requested source; valid while irq_req=1.
- irq_ack  in  1  CPU accepts the request; sampled only while irq_req=1.
- ret_pc  in  ADDR_W  return PC, captured on the ack.
- iret  in  1  end of the current handler.
- addr_valid  out  1  one-cycle pulse marking addr_out as valid.
- addr_out  out  ADDR_W  handler vector or popped return PC.
- act_valid  out  1  stack depth is greater than 0.
- act_id  out  $clog2(NUM_INT)  ID at the top of the stack.
- iret_err  out  1  sticky flag: iret was issued while the stack was empty.

Behaviour:
- **Reset (rst=0 at a clk edge):**
  - ier, pending, source-history register, stack, depth and iret_err all return to 0.
  - FSM goes to IDLE.
  - All outputs are 0.
  - Reset asserted mid-operation discards nested state with no return address emitted.
  - Because history resets to 0, a source held high when reset releases counts as an edge.
- **Edge capture:**
  - Set condition for bit i: irq_src[i]=1 and history[i]=0. history <= irq_src every cycle.
  - pending[i] is 1 on the edge after the rising source is sampled.
  - If set and pend_clr hit the same bit in the same cycle, set wins.
- **Enable register:** an ier write takes effect the next cycle. ier_q is the registered value.
- **Candidate selection:**
  - elig = pending & ier[NUM_INT-1:0], gated by ier[NUM_INT].
  - Candidate = lowest set index of elig.
  - Preemption: when act_valid=1, only a candidate with index < act_id is valid.
  - No candidate is valid while depth == NEST_DEPTH, so the stack cannot overflow.
- **FSM states:** IDLE, REQ, DISPATCH, RETURN.
  - **IDLE:**
    - iret takes precedence over everything else and moves to RETURN.
    - Otherwise, a valid candidate moves to REQ with irq_id <= candidate.
  - **REQ:**
    - irq_req=1. irq_id is re-latched every cycle to the current candidate, so a newly arrived higher-priority source replaces the request.
    - No valid candidate: go to IDLE; irq_req drops the next cycle.
    - iret=1: go to RETURN; iret beats ack in the same cycle and the request is withdrawn.
    - irq_ack=1 (no iret):
      - push {ret_pc, irq_id}; depth increments;
      - clear pending[irq_id];
      - go to DISPATCH.
  - **DISPATCH:** one cycle.
    - addr_valid=1, addr_out = VEC_BASE + act_id*VEC_STRIDE, truncated to ADDR_W.
    - Then go to IDLE.
  - **RETURN:** one cycle.
    - If depth>0: pop; addr_valid=1; addr_out = popped PC.
    - If depth==0: addr_valid=0 and iret_err is set. iret_err stays set until reset.
    - Then go to IDLE.
- **Latency:** from the source edge being sampled, irq_req rises after 2 clocks. From ack, addr_valid asserts on the next cycle. From iret in IDLE, the return address appears on the next cycle.
- **Idle outputs:** addr_out=0 whenever addr_valid=0.
- **Priority stability:** iret, ack and the pending clear all act on the registered state, so a source re-asserting during its own handler re-pends and is served after iret.

Test Plan (defaults, VEC_BASE=0x0100, VEC_STRIDE=4):
- ier=0x1_0008, pulse irq_src[3] → irq_req=1 with irq_id=3 after 2 clocks; ack with ret_pc=0x0040 → addr_out=0x010C (addr_valid=1); pending[3]=0; act_id=3.
- Continuing that sequence: iret → next cycle addr_out=0x0040 with addr_valid=1; act_valid=0.
- ier=0x1_FFFF, sources 5 and 2 rise in the same cycle → irq_id=2. After its ack, irq_id=5 is not requested until iret.
- While servicing 5, source 1 rises → request for id 1 (preempt), push. Source 6 arriving at the same time → not requested. Two irets → return PCs popped in LIFO order.
- Nest 4 levels (ids 3, 2, 1, 0), then raise all sources → irq_req stays 0. Back-to-back irets pop 4 PCs. A 5th iret → iret_err=1 and no addr_valid.
- Global enable=0 with pending=0x0010 → no request. Set global enable → request for id 4. Pull rst low while in REQ → all outputs 0 next cycle; pending=0.
